// File: rtl/btn_evt_pkg.sv
// -----------------------------------------------------------------------------
// btn_evt_pkg
// Shared definitions for the button event arbiter and its event FIFO.
//   EVT_DOWN / EVT_UP : encoding of the event type bit (LSB of an event word)
//   clog2()           : constant ceil(log2(n)), usable in parameter expressions
//   evt_width()       : event-word width for a given button count
//                       {button index, is_up} = clog2(n_btn) + 1 bits
// -----------------------------------------------------------------------------
package btn_evt_pkg;

  localparam logic EVT_DOWN = 1'b0;
  localparam logic EVT_UP   = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int evt_width(input int n_btn);
    return clog2(n_btn) + 1;
  endfunction

  localparam int N_BTN_DEFAULT = 4;
  localparam int EVT_W_DEFAULT = evt_width(N_BTN_DEFAULT);

endpackage

// File: rtl/evt_fifo.sv
// -----------------------------------------------------------------------------
// evt_fifo
// Generic synchronous show-ahead FIFO. The head entry is visible on dout
// whenever the FIFO is non-empty; dout reads as zero while empty.
// A push while full is accepted only together with a pop.
//   clk   : clock, all state on posedge
//   rst   : synchronous active-high reset
//   push  : write din this cycle
//   din   : data to write
//   pop   : remove head entry this cycle (ignored when empty)
//   dout  : head entry
//   count : number of stored entries (0..DEPTH)
//   full  : count == DEPTH
//   empty : count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module evt_fifo
  import btn_evt_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic [clog2(DEPTH):0] count,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // NOTE: storage has no reset; only pointers and count define validity,
  // which keeps the array as plain RAM. dout is masked so stale data never shows.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every reader sees the pre-edge value regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/btn_event_arbiter.sv
// -----------------------------------------------------------------------------
// btn_event_arbiter
// Collects 1-cycle press/release pulses from N_BTN debounced buttons into
// one-entry pending slots, moves one pending event per cycle (round-robin)
// into a show-ahead FIFO, and hands events to a single consumer via
// valid/ready.
//   clk       : clock
//   rst       : synchronous active-high reset
//   btn_down  : per-button press pulse
//   btn_up    : per-button release pulse
//   evt_valid : FIFO head holds an event
//   evt_btn   : button index of the head event
//   evt_is_up : 0 = press, 1 = release
//   evt_ready : consumer accepts the head event this cycle
//   overflow  : sticky, at least one pulse was dropped
//   ovf_clr   : clears overflow (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module btn_event_arbiter
  import btn_evt_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_BTN-1:0]        btn_down,
  input  logic [N_BTN-1:0]        btn_up,
  output logic                    evt_valid,
  output logic [clog2(N_BTN)-1:0] evt_btn,
  output logic                    evt_is_up,
  input  logic                    evt_ready,
  output logic                    overflow,
  input  logic                    ovf_clr
);

  localparam int BTN_W = clog2(N_BTN);
  localparam int EVT_W = evt_width(N_BTN);
  localparam int CW    = clog2(FIFO_DEPTH) + 1;

  logic [N_BTN-1:0] r_pend_v;
  logic [N_BTN-1:0] r_pend_up;
  logic [BTN_W-1:0] r_rr_ptr;
  logic             r_overflow;

  logic             w_found;
  logic [BTN_W-1:0] w_gnt_idx;
  logic             w_grant;
  logic [N_BTN-1:0] w_gnt_vec;
  logic [N_BTN-1:0] w_pulse;
  logic [N_BTN-1:0] w_busy;
  logic [N_BTN-1:0] w_load;
  logic [N_BTN-1:0] w_drop;
  logic [BTN_W-1:0] w_rr_next;
  logic             w_pop;
  logic             w_push_ok;
  logic [EVT_W-1:0] w_din;
  logic [EVT_W-1:0] w_dout;
  logic [CW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;

  assign w_pop     = evt_ready & ~w_empty;
  // A full FIFO still accepts a push in the same cycle as a pop.
  assign w_push_ok = ~w_full | w_pop;

  // Round-robin search starting at r_rr_ptr, wrapping modulo N_BTN.
  // NOTE: every variable assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    int j;
    j         = 0;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < N_BTN; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= N_BTN) j = j - N_BTN;
      if (!w_found && r_pend_v[BTN_W'(j)]) begin
        w_found   = 1'b1;
        w_gnt_idx = BTN_W'(j);
      end
    end
  end

  assign w_grant   = w_found & w_push_ok;
  assign w_gnt_vec = w_grant ? (N_BTN'(1) << w_gnt_idx) : '0;
  assign w_rr_next = (w_gnt_idx == BTN_W'(N_BTN - 1)) ? '0 : w_gnt_idx + BTN_W'(1);

  // A slot being granted this cycle counts as free, so a new pulse refills it.
  assign w_pulse = btn_down | btn_up;
  assign w_busy  = r_pend_v & ~w_gnt_vec;
  assign w_load  = w_pulse & ~w_busy;
  // Dropped: any pulse on a busy slot, or the release half of a down+up pair.
  assign w_drop  = (w_pulse & w_busy) | (btn_down & btn_up);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_v   <= '0;
      r_pend_up  <= '0;
      r_rr_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pend_v  <= (r_pend_v & ~w_gnt_vec) | w_load;
      // Press wins when both arrive, so a loaded slot is "up" only without a down.
      r_pend_up <= (r_pend_up & ~w_load) | (w_load & ~btn_down);
      if (w_grant) r_rr_ptr <= w_rr_next;
      if (|w_drop)      r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

  assign w_din = {w_gnt_idx, r_pend_up[w_gnt_idx]};

  evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_grant),
    .din   (w_din),
    .pop   (w_pop),
    .dout  (w_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign evt_valid = (w_count != '0);
  assign evt_btn   = w_dout[EVT_W-1:1];
  assign evt_is_up = w_dout[0];
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_btn_event_arbiter
// Directed bench for btn_event_arbiter (N_BTN=4, FIFO_DEPTH=4). Inputs change
// 1 time unit after a rising edge; outputs are checked at that same point,
// i.e. they show the state produced by that edge.
// -----------------------------------------------------------------------------
module tb_btn_event_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] btn_down;
  logic [3:0] btn_up;
  logic       evt_valid;
  logic [1:0] evt_btn;
  logic       evt_is_up;
  logic       evt_ready;
  logic       overflow;
  logic       ovf_clr;

  int n_checks = 0;
  int n_errors = 0;

  btn_event_arbiter #(
    .N_BTN      (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_down  (btn_down),
    .btn_up    (btn_up),
    .evt_valid (evt_valid),
    .evt_btn   (evt_btn),
    .evt_is_up (evt_is_up),
    .evt_ready (evt_ready),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_evt(input string tag, input logic v, input logic [1:0] b, input logic up);
    check({tag, ".valid"}, 32'(evt_valid), 32'(v));
    if (v) begin
      check({tag, ".btn"}, 32'(evt_btn), 32'(b));
      check({tag, ".is_up"}, 32'(evt_is_up), 32'(up));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin : stim
    logic [1:0] exp_order [4];
    logic [1:0] drain_btn [6];
    logic [2:0] drain_cnt [6];

    rst = 1'b1; btn_down = '0; btn_up = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    check("rst.valid", 32'(evt_valid), 0);
    check("rst.btn",   32'(evt_btn),   0);
    check("rst.is_up", 32'(evt_is_up), 0);
    check("rst.ovf",   32'(overflow),  0);
    rst = 1'b0;

    // Single press on button 2: valid two edges after the pulse, one cycle long.
    evt_ready = 1'b1;
    btn_down = 4'b0100; tick(); btn_down = '0;
    check_evt("single.t1", 1'b0, 2'd0, 1'b0);
    tick();
    check_evt("single.t2", 1'b1, 2'd2, 1'b0);
    tick();
    check_evt("single.t3", 1'b0, 2'd0, 1'b0);
    check("single.ovf", 32'(overflow), 0);

    // Release on button 3 carries is_up = 1.
    btn_up = 4'b1000; tick(); btn_up = '0;
    tick();
    check_evt("release", 1'b1, 2'd3, 1'b1);
    tick();

    // All four pressed with rr_ptr = 0: order 0,1,2,3.
    do_reset();
    btn_down = 4'b1111; tick(); btn_down = '0;
    check_evt("rr0.t1", 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_evt($sformatf("rr0.e%0d", i), 1'b1, 2'(i), 1'b0);
    end
    tick();
    check_evt("rr0.end", 1'b0, 2'd0, 1'b0);

    // One grant of button 1 moves rr_ptr to 2: order 2,3,0,1.
    do_reset();
    btn_down = 4'b0010; tick(); btn_down = '0;
    tick(); tick();
    btn_down = 4'b1111; tick(); btn_down = '0;
    exp_order = '{2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 4; i++) begin
      tick();
      check_evt($sformatf("rr2.e%0d", i), 1'b1, exp_order[i], 1'b0);
    end
    tick();
    check_evt("rr2.end", 1'b0, 2'd0, 1'b0);

    // Fill with the consumer stalled, then drain.
    do_reset();
    evt_ready = 1'b0;
    btn_down = 4'b1111; tick(); btn_down = '0;
    tick(); tick(); tick(); tick();
    check("fill.cnt4", 32'(dut.u_fifo.count), 4);
    btn_down = 4'b0011; tick(); btn_down = '0;
    tick();
    check("fill.cnt_hold", 32'(dut.u_fifo.count), 4);
    check_evt("fill.head", 1'b1, 2'd0, 1'b0);
    check("fill.no_ovf", 32'(overflow), 0);
    btn_down = 4'b0001; tick(); btn_down = '0;
    check("fill.ovf_set", 32'(overflow), 1);

    // Push+pop while full keeps count at 4 for two cycles, then it falls.
    evt_ready = 1'b1;
    drain_btn = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    drain_cnt = '{3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    for (int i = 0; i < 6; i++) begin
      check_evt($sformatf("drain.e%0d", i), 1'b1, drain_btn[i], 1'b0);
      tick();
      check($sformatf("drain.cnt%0d", i), 32'(dut.u_fifo.count), 32'(drain_cnt[i]));
    end
    check_evt("drain.end", 1'b0, 2'd0, 1'b0);
    check("drain.ovf_sticky", 32'(overflow), 1);

    // Same-button down+up: only the press survives, overflow set, then cleared.
    do_reset();
    btn_down = 4'b0010; btn_up = 4'b0010; tick(); btn_down = '0; btn_up = '0;
    check("both.ovf", 32'(overflow), 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("both.ovf_clr", 32'(overflow), 0);
    check_evt("both.evt", 1'b1, 2'd1, 1'b0);
    tick();
    check_evt("both.none1", 1'b0, 2'd0, 1'b0);
    tick();
    check_evt("both.none2", 1'b0, 2'd0, 1'b0);

    // A drop in the same cycle as ovf_clr keeps overflow set.
    btn_down = 4'b0001; btn_up = 4'b0001; ovf_clr = 1'b1; tick();
    btn_down = '0; btn_up = '0; ovf_clr = 1'b0;
    check("ovf_prio", 32'(overflow), 1);
    tick(); tick();

    // Reset with 3 queued and 2 pending events.
    do_reset();
    evt_ready = 1'b0;
    btn_down = 4'b0111; tick(); btn_down = '0;
    tick(); tick(); tick();
    btn_down = 4'b1001; btn_up = 4'b0001; tick(); btn_down = '0; btn_up = '0;
    check("mid.cnt3", 32'(dut.u_fifo.count), 3);
    check("mid.ovf", 32'(overflow), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    evt_ready = 1'b1;
    check_evt("mid.rst", 1'b0, 2'd0, 1'b0);
    check("mid.rst_ovf", 32'(overflow), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_evt($sformatf("mid.stale%0d", i), 1'b0, 2'd0, 1'b0);
    end
    btn_down = 4'b0100; tick(); btn_down = '0;
    tick();
    check_evt("mid.new", 1'b1, 2'd2, 1'b0);
    tick();
    check_evt("mid.new_gone", 1'b0, 2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
